// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default sizes and address-0 masking for regfile_sb
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF = 2;
  function automatic logic live(input logic is_zero, input logic zero_reg);
    return !(is_zero && zero_reg);
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: ID/WB-facing bundle of the register file.
// Ports: writeback (we_i/wa_i/wd_i), packed read ports (ra_i/rd_o/busy_o),
// scoreboard set (sb_set_i/sb_addr_i), clear engine (clr_req_i/clr_busy_o/clr_done_o).
interface regfile_sb_if #(
  parameter int XLEN = regfile_pkg::XLEN_DEF,
  parameter int NREG = regfile_pkg::NREG_DEF,
  parameter int NRD = regfile_pkg::NRD_DEF
);
  localparam int AW = $clog2(NREG);
  logic we_i;
  logic [AW-1:0] wa_i;
  logic [XLEN-1:0] wd_i;
  logic [NRD*AW-1:0] ra_i;
  logic [NRD*XLEN-1:0] rd_o;
  logic [NRD-1:0] busy_o;
  logic sb_set_i;
  logic [AW-1:0] sb_addr_i;
  logic clr_req_i;
  logic clr_busy_o;
  logic clr_done_o;
  modport master (
    output we_i, wa_i, wd_i, ra_i, sb_set_i, sb_addr_i, clr_req_i,
    input rd_o, busy_o, clr_busy_o, clr_done_o
  );
  modport slave (
    input we_i, wa_i, wd_i, ra_i, sb_set_i, sb_addr_i, clr_req_i,
    output rd_o, busy_o, clr_busy_o, clr_done_o
  );
endinterface

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequential clear engine walking every register index once.
// Ports: clk, rst (async high), clr_req_i in; clr_active (wipe entry clr_idx this
// cycle), clr_idx, clr_busy_o (CLEAR or DONE), clr_done_o (one-cycle DONE pulse) out.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW = $clog2(NREG)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_req_i,
  output logic clr_active,
  output logic [AW-1:0] clr_idx,
  output logic clr_busy_o,
  output logic clr_done_o
);
  clr_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic last;
  assign last = idx_q == AW'(NREG - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
  end
  // idx holds at NREG-1 on the final clear so it never wraps
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (clr_req_i) begin
        state_d = CLEAR;
        idx_d = '0;
      end
      CLEAR: begin
        state_d = last ? DONE : CLEAR;
        idx_d = last ? idx_q : idx_q + AW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    clr_active = state_q == CLEAR;
    clr_idx = idx_q;
    clr_busy_o = state_q != IDLE;
    clr_done_o = state_q == DONE;
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with pending-write scoreboard and clear engine.
// Ports: clk, rst (async high), bus (regfile_sb_if.slave): writeback, NRD combinational
// read ports with busy bits, scoreboard set, clear request/status.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle writeback data to read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic ZR = ZERO_REG != 0;
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic clr_active;
  logic [AW-1:0] clr_idx;
  logic idle, wr_ok, set_ok;
  regfile_clr_fsm #(.NREG(NREG), .AW(AW)) u_clr (
    .clk(clk),
    .rst(rst),
    .clr_req_i(bus.clr_req_i),
    .clr_active(clr_active),
    .clr_idx(clr_idx),
    .clr_busy_o(bus.clr_busy_o),
    .clr_done_o(bus.clr_done_o)
  );
  assign idle = !bus.clr_busy_o;
  assign wr_ok = bus.we_i && idle && live(bus.wa_i == '0, ZR);
  assign set_ok = bus.sb_set_i && idle && live(bus.sb_addr_i == '0, ZR);
  // set is applied after write so a same-cycle new producer leaves the entry busy
  always_comb begin
    mem_d = mem_q;
    busy_d = busy_q;
    if (clr_active) begin
      mem_d[clr_idx] = '0;
      busy_d[clr_idx] = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_d[bus.wa_i] = bus.wd_i;
        busy_d[bus.wa_i] = 1'b0;
      end
      if (set_ok) busy_d[bus.sb_addr_i] = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      mem_q <= mem_d;
      busy_q <= busy_d;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic ok, hit, pend;
    assign ra = bus.ra_i[k*AW +: AW];
    assign ok = live(ra == '0, ZR);
`ifdef REGFILE_BYPASS_EN
    assign hit = wr_ok && ra == bus.wa_i;
`else
    assign hit = 1'b0;
`endif
    // a same-cycle scoreboard set on the bypassed address cancels forwarding
    assign pend = set_ok && ra == bus.sb_addr_i;
    assign bus.rd_o[k*XLEN +: XLEN] = !ok ? '0 : (hit && !pend) ? bus.wd_i : mem_q[ra];
    assign bus.busy_o[k] = ok && (hit ? pend : busy_q[ra]);
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb against an array-level reference model
module tb_regfile_sb;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_sb_if #(.XLEN(32), .NREG(N), .NRD(2)) bus ();
  regfile_sb #(.XLEN(32), .NREG(N), .NRD(2), .ZERO_REG(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    logic [63:0] rd;
    logic [1:0] bsy;
    logic cb;
    logic cd;
  } exp_t;
  typedef struct {
    bit chk;
    int eb;
    int ed;
  } ctl_t;
  exp_t exp_q[$];
  ctl_t ctl_q[$];
  int compared = 0;
  int mismatched = 0;
  logic [31:0] m_mem [N];
  bit m_busy [N];
  int ph = -1;
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask
  initial begin
    int nb, nd, bb, bd;
    exp_t e;
    ctl_t c;
    nb = 0; nd = 0; bb = 0; bd = 0;
    forever begin
      @(negedge clk);
      if (bus.clr_busy_o) nb++;
      if (bus.clr_done_o) nd++;
      if (ctl_q.size() > 0) begin
        c = ctl_q.pop_front();
        if (!c.chk) begin
          bb = nb;
          bd = nd;
        end else begin
          check("clr_busy_cycles", 64'(nb - bb), 64'(c.eb));
          check("clr_done_pulses", 64'(nd - bd), 64'(c.ed));
        end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd0", 64'(bus.rd_o[31:0]), 64'(e.rd[31:0]));
        check("rd1", 64'(bus.rd_o[63:32]), 64'(e.rd[63:32]));
        check("busy", 64'(bus.busy_o), 64'(e.bsy));
        check("clr_busy", 64'(bus.clr_busy_o), 64'(e.cb));
        check("clr_done", 64'(bus.clr_done_o), 64'(e.cd));
      end
    end
  end
  function automatic void step();
    if (ph == -1) begin
      if (bus.we_i && bus.wa_i != 5'd0) begin
        m_mem[bus.wa_i] = bus.wd_i;
        m_busy[bus.wa_i] = 1'b0;
      end
      if (bus.sb_set_i && bus.sb_addr_i != 5'd0) m_busy[bus.sb_addr_i] = 1'b1;
      if (bus.clr_req_i) ph = 0;
    end else if (ph < N) begin
      m_mem[ph] = '0;
      m_busy[ph] = 1'b0;
      ph++;
    end else ph = -1;
  endfunction
  function automatic logic [32:0] port(input int a);
    bit hit, pend;
    hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
    hit = ph == -1 && bus.we_i && bus.wa_i == 5'(a) && a != 0;
`endif
    pend = bus.sb_set_i && bus.sb_addr_i == 5'(a);
    if (a == 0) return '0;
    if (hit) return pend ? {1'b1, m_mem[a]} : {1'b0, bus.wd_i};
    return {m_busy[a], m_mem[a]};
  endfunction
  task automatic cycle(input bit r, input bit w, input int wa, input logic [31:0] wd,
                       input int a0, input int a1, input bit s, input int sa, input bit q);
    exp_t e;
    logic [32:0] p0, p1;
    @(posedge clk);
    #1;
    if (!rst) step();
    rst = r;
    bus.we_i = w;
    bus.wa_i = 5'(wa);
    bus.wd_i = wd;
    bus.ra_i = {5'(a1), 5'(a0)};
    bus.sb_set_i = s;
    bus.sb_addr_i = 5'(sa);
    bus.clr_req_i = q;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_mem[i] = '0;
        m_busy[i] = 1'b0;
      end
      ph = -1;
    end
    p0 = port(a0);
    p1 = port(a1);
    e.rd = {p1[31:0], p0[31:0]};
    e.bsy = {p1[32], p0[32]};
    e.cb = ph != -1;
    e.cd = ph == N;
    exp_q.push_back(e);
  endtask
  task automatic idle_read(input int a0, input int a1);
    cycle(0, 0, 0, 0, a0, a1, 0, 0, 0);
  endtask
  initial begin
    bus.we_i = 0; bus.wa_i = 0; bus.wd_i = 0; bus.ra_i = 0;
    bus.sb_set_i = 0; bus.sb_addr_i = 0; bus.clr_req_i = 0;
    cycle(1, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) idle_read(i, i);
    cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle_read(5, 0);
    cycle(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
    idle_read(0, 5);
    cycle(0, 0, 0, 0, 7, 0, 1, 7, 0);
    idle_read(7, 7);
    cycle(0, 1, 7, 32'h55, 7, 0, 1, 7, 0);
    idle_read(7, 0);
    cycle(0, 1, 7, 32'h77, 7, 0, 0, 0, 0);
    idle_read(7, 5);
    for (int i = 1; i < N; i++) cycle(0, 1, i, i, i, 0, 0, 0, 0);
    ctl_q.push_back('{chk: 1'b0, eb: 0, ed: 0});
    cycle(0, 0, 0, 0, 1, 31, 0, 0, 1);
    for (int i = 0; i < 34; i++)
      cycle(0, i % 3 == 0, 1 + i % 31, $urandom, i % N, 31 - i % N, i % 5 == 0, 1 + i % 31, 0);
    for (int i = 0; i < N; i++) idle_read(i, N - 1 - i);
    ctl_q.push_back('{chk: 1'b1, eb: 33, ed: 1});
    idle_read(0, 0);
    for (int i = 1; i < 6; i++) cycle(0, 1, i, 32'hC0DE0000 + i, i, 0, 0, 0, 0);
    ctl_q.push_back('{chk: 1'b0, eb: 0, ed: 0});
    cycle(0, 0, 0, 0, 3, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) idle_read(i, 3);
    cycle(1, 0, 0, 0, 3, 4, 0, 0, 0);
    idle_read(3, 4);
    ctl_q.push_back('{chk: 1'b1, eb: 10, ed: 0});
    idle_read(0, 0);
    cycle(0, 1, 9, 32'hA5A5A5A5, 9, 9, 0, 0, 0);
    idle_read(9, 0);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, N - 1),
            $urandom, $urandom_range(0, N - 1), $urandom_range(0, N - 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, N - 1), $urandom_range(0, 59) == 0);
    idle_read(0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the next core generation, replacing the fixed 32x32, two-read-port file.
- Generalised in data width, register count and number of read ports.
- Adds a per-register scoreboard of pending-write busy bits and a sequential hardware clear engine for flush/context reset.
- Sits between ID (reads, scoreboard set) and WB (write, scoreboard clear).

Parameters:
- XLEN, 32: data width in bits.
- NREG, 32: number of registers (power of 2, >=2); AW = $clog2(NREG).
- NRD, 2: number of combinational read ports (1..4).
- ZERO_REG, 1: 1 = entry 0 is hardwired zero, never written, never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- we_i  in  1  writeback enable.
- wa_i  in  AW  writeback address.
- wd_i  in  XLEN  writeback data.
- ra_i  in  NRD*AW  packed read addresses, port k at [k*AW +: AW].
- rd_o  out  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN].
- busy_o  out  NRD  busy bit of the register addressed by port k.
- sb_set_i  in  1  issue: mark sb_addr_i pending.
- sb_addr_i  in  AW  register to mark pending.
- clr_req_i  in  1  start a sequential clear.
- clr_busy_o  out  1  clear engine active.
- clr_done_o  out  1  one-cycle pulse at clear completion.

Behaviour:
- Reset (async, rst=1): all entries = 0, all busy bits = 0, FSM = IDLE, clr_busy_o = 0, clr_done_o = 0. rd_o and busy_o reflect the cleared array.
- Read path: combinational, zero latency.
  - rd_o[k] = mem[ra_k]; busy_o[k] = busy[ra_k].
  - With ZERO_REG=1, address 0 always reads 0 with busy 0.
- Write: on posedge, when we_i=1 and FSM=IDLE, mem[wa_i] <= wd_i and busy[wa_i] <= 0.
  - Writes to address 0 are dropped when ZERO_REG=1.
- Scoreboard set: on posedge, when sb_set_i=1 and FSM=IDLE, busy[sb_addr_i] <= 1.
  - Ignored for address 0 when ZERO_REG=1.
  - Same-cycle set and write to the same address: data is written and busy ends 1 (the new producer wins).
  - Set to an already-busy register: stays 1, no error.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clr_req_i=1; idx <= 0.
  - CLEAR: each cycle mem[idx] <= 0, busy[idx] <= 0, idx <= idx+1. Takes exactly NREG cycles.
  - CLEAR -> DONE on the cycle idx = NREG-1 is cleared.
  - DONE: clr_done_o=1 for exactly one cycle, then -> IDLE.
  - clr_busy_o = 1 in CLEAR and DONE.
- During CLEAR/DONE: we_i, sb_set_i and clr_req_i are ignored. Reads return current array contents (partially cleared).
- clr_req_i held high in IDLE after DONE starts a new clear.
- rst asserted mid-clear aborts immediately to the reset state.
- idx counter is AW bits; no wrap beyond NREG-1 is ever taken.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose address equals wa_i while we_i=1 and FSM=IDLE (and the address is nonzero when ZERO_REG=1) returns wd_i on rd_o and 0 on busy_o in the same cycle. Bypass is suppressed when sb_set_i targets the same address that cycle, so busy_o is 1.
- Undefined: rd_o and busy_o show the pre-write registered values until the next cycle.

Decomposition:
- Shared package regfile_pkg:
  - clr_state_e enum {IDLE, CLEAR, DONE}.
  - Default XLEN/NREG constants.
  - Function for address-0 masking.
- One sub-module, regfile_clr_fsm: clear sequencer owning the state and idx counter. Outputs clr_active, clr_idx, clr_busy_o, clr_done_o.

Test Plan:
- Reset, then read all 32 addresses on both ports -> rd_o=0, busy_o=0 for every address.
- Write x5=0xDEADBEEF, next cycle read x5 on port0 and x0 on port1 -> 0xDEADBEEF / 0. Write x0=0x1234, then read x0 -> 0.
- sb_set x7; next cycle busy_o=1. Same-cycle sb_set x7 + write x7=0x55 -> busy stays 1, data 0x55. Write-only x7 -> busy 0.
- Fill x1..x31 with their indices, pulse clr_req_i -> clr_busy_o high 33 cycles, clr_done_o single pulse at cycle 33, all regs 0. A we_i issued mid-clear has no effect.
- Assert rst at clear cycle 10 -> FSM IDLE, clr_busy_o=0 immediately, no clr_done_o pulse.
- With REGFILE_BYPASS_EN: we_i x9=0xA5A5A5A5 and read x9 in the same cycle -> rd_o=0xA5A5A5A5, busy_o=0. Without the macro -> old value that cycle, new value next cycle.
